// File: rtl/countdown_pkg.sv
// Shared types and helpers for the N-phase countdown sequencer.
// Latency: n/a (package). Backpressure: n/a.
// Provides the FSM encoding, phase slicing of the packed duration bus and BCD digit sizing.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET   = 2'd1,
        RUN   = 2'd2,
        PAUSE = 2'd3
    } cd_state_t;

    // Upper bounds for the generic slice helper; callers size-cast in and out.
    localparam int CD_TMAX = 1024;
    localparam int CD_WMAX = 32;

    // Phase i of a packed bus of nphase fields, width bits each, phase 0 in the MSBs.
    function automatic logic [CD_WMAX-1:0] get_phase(input logic [CD_TMAX-1:0] t,
                                                     input int i,
                                                     input int nphase,
                                                     input int width);
        logic [CD_TMAX-1:0] sh;
        logic [CD_WMAX-1:0] r;
        int                 base;
        r    = '0;
        base = (nphase - 1 - i) * width;
        sh   = (base >= 0) ? (t >> base) : '0;
        for (int b = 0; b < CD_WMAX; b++) begin
            if (b < width) r[b] = sh[b];
        end
        return r;
    endfunction

    // Decimal digits needed for the largest width-bit value, i.e. ceil(width*log10(2)).
    function automatic int bcd_digits(input int width);
        logic [63:0] v;
        int          d;
        v = (64'd1 << width) - 64'd1;
        d = 0;
        do begin
            d++;
            v = v / 64'd10;
        end while (v != 64'd0);
        return d;
    endfunction

endpackage

// File: rtl/cd_prescaler.sv
// Tick prescaler: counts 0..PRESCALE-1 while en, tc marks the terminal count.
// Latency: tc is combinational on the cycle the count sits at PRESCALE-1 with en high.
// Backpressure: en=0 holds the partial count; clr (or RST) restarts from zero.
module cd_prescaler #(
    parameter int PRESCALE = 1048576
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tc = en && (cnt == LAST);

endmodule

// File: rtl/phase_countdown_seq.sv
// N-phase countdown sequencer over packed durations t; optional BCD output when COUNTDOWN_BCD_EN is defined.
// Latency: all outputs registered; they change on the edge where the prescaler terminal count or a reload is seen.
// Backpressure: none; En=0 pauses in place, enSet forces reload of phase 0 and overrides En.
module phase_countdown_seq
    import countdown_pkg::*;
#(
    parameter  int NPHASE   = 3,
    parameter  int WIDTH    = 7,
    parameter  int PRESCALE = 1048576,
    localparam int IDX_W    = (NPHASE > 1) ? $clog2(NPHASE) : 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    En,
    input  logic                    enSet,
    input  logic [NPHASE*WIDTH-1:0] t,
    output logic [IDX_W-1:0]        select,
    output logic [WIDTH-1:0]        Q,
    output logic                    tick,
    output logic                    phase_done,
    output logic                    cycle_done
`ifdef COUNTDOWN_BCD_EN
    ,
    output logic [4*bcd_digits(WIDTH)-1:0] Q_bcd
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPHASE - 1);

    cd_state_t         state_q, state_nxt;
    logic              load, run_en, tc;
    logic              wrap;
    logic [IDX_W-1:0]  sel_inc, sel_nxt;
    logic [WIDTH-1:0]  q_nxt, t_first, t_next;
    logic              tick_nxt, pd_nxt, cd_nxt;

    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        if (enSet) begin
            state_nxt = SET;
        end else begin
            case (state_q)
                IDLE:    state_nxt = IDLE;
                default: state_nxt = En ? RUN : PAUSE;
            endcase
        end
    end

    // The first cycle after enSet drops already counts when En is high.
    always_comb begin
        load   = enSet;
        run_en = !enSet && En && (state_q != IDLE);
    end

    cd_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .CLK (CLK),
        .RST (RST),
        .clr (load),
        .en  (run_en),
        .tc  (tc)
    );

    always_comb begin
        wrap     = (select == LAST_IDX);
        sel_inc  = wrap ? '0 : select + 1'b1;
        t_first  = WIDTH'(get_phase(CD_TMAX'(t), 0, NPHASE, WIDTH));
        t_next   = WIDTH'(get_phase(CD_TMAX'(t), int'(sel_inc), NPHASE, WIDTH));
        q_nxt    = Q;
        sel_nxt  = select;
        tick_nxt = 1'b0;
        pd_nxt   = 1'b0;
        cd_nxt   = 1'b0;
        if (load) begin
            q_nxt   = t_first;
            sel_nxt = '0;
        end else if (tc) begin
            tick_nxt = 1'b1;
            if (Q != '0) begin
                q_nxt = Q - 1'b1;
            end else begin
                sel_nxt = sel_inc;
                q_nxt   = t_next;
                pd_nxt  = 1'b1;
                cd_nxt  = wrap;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            select     <= '0;
            Q          <= '0;
            tick       <= 1'b0;
            phase_done <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            select     <= sel_nxt;
            Q          <= q_nxt;
            tick       <= tick_nxt;
            phase_done <= pd_nxt;
            cycle_done <= cd_nxt;
        end
    end

`ifdef COUNTDOWN_BCD_EN
    // Converts the next Q so the BCD register moves on the same edge as Q.
    if (WIDTH > 0) begin : g_bcd
        localparam int BCD_DIG = bcd_digits(WIDTH);

        logic [4*BCD_DIG-1:0] bcd_nxt;

        always_comb begin
            bcd_nxt = '0;
            for (int i = WIDTH - 1; i >= 0; i--) begin
                for (int d = 0; d < BCD_DIG; d++) begin
                    if (bcd_nxt[4*d +: 4] > 4'd4) bcd_nxt[4*d +: 4] = bcd_nxt[4*d +: 4] + 4'd3;
                end
                bcd_nxt = {bcd_nxt[4*BCD_DIG-2:0], q_nxt[i]};
            end
        end

        always_ff @(posedge CLK) begin
            if (RST) Q_bcd <= '0;
            else     Q_bcd <= bcd_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_phase_countdown_seq.sv
// Directed self-checking bench for phase_countdown_seq (NPHASE=3, WIDTH=7, PRESCALE=4).
// Checks Q_bcd as well when COUNTDOWN_BCD_EN is defined.
module tb_phase_countdown_seq;

    localparam int NPHASE   = 3;
    localparam int WIDTH    = 7;
    localparam int PRESCALE = 4;

    logic                    CLK = 1'b0;
    logic                    RST;
    logic                    En;
    logic                    enSet;
    logic [NPHASE*WIDTH-1:0] t;
    logic [1:0]              select;
    logic [WIDTH-1:0]        Q;
    logic                    tick;
    logic                    phase_done;
    logic                    cycle_done;
`ifdef COUNTDOWN_BCD_EN
    logic [11:0]             Q_bcd;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    phase_countdown_seq #(
        .NPHASE   (NPHASE),
        .WIDTH    (WIDTH),
        .PRESCALE (PRESCALE)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .En         (En),
        .enSet      (enSet),
        .t          (t),
        .select     (select),
        .Q          (Q),
        .tick       (tick),
        .phase_done (phase_done),
        .cycle_done (cycle_done)
`ifdef COUNTDOWN_BCD_EN
        ,
        .Q_bcd      (Q_bcd)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Steps until tick is seen (bounded); n is the number of edges taken.
    task automatic wait_tick(input string tag, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!tick && n < 64);
        check({tag, "_tick"}, 32'(tick), 32'd1);
    endtask

    initial begin
        int n;
        int bad;
        logic [WIDTH-1:0] q0;
        logic [1:0]       s0;

        RST = 1'b1; En = 1'b0; enSet = 1'b0; t = '0;
        step(2);
        check("rst_q",   32'(Q), 32'd0);
        check("rst_sel", 32'(select), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);

        // En alone must not leave IDLE
        RST = 1'b0; En = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (tick || Q != '0 || select != '0 || phase_done) bad++;
        end
        check("idle_hold", 32'(bad), 32'd0);

        // durations phase0=2, phase1=0, phase2=1
        t = {7'd2, 7'd0, 7'd1};
        enSet = 1'b1;
        step(1);
        check("set_q",   32'(Q), 32'd2);
        check("set_sel", 32'(select), 32'd0);
        enSet = 1'b0;

        wait_tick("p0a", n);
        check("p0a_lat", 32'(n), 32'd4);
        check("p0a_q",   32'(Q), 32'd1);
        check("p0a_pd",  32'(phase_done), 32'd0);
        step(1);
        check("tick_pulse", 32'(tick), 32'd0);
        wait_tick("p0b", n);
        check("p0b_lat", 32'(n), 32'd3);
        check("p0b_q",   32'(Q), 32'd0);

        wait_tick("p1", n);
        check("p1_lat", 32'(n), 32'd4);
        check("p1_sel", 32'(select), 32'd1);
        check("p1_q",   32'(Q), 32'd0);
        check("p1_pd",  32'(phase_done), 32'd1);
        check("p1_cd",  32'(cycle_done), 32'd0);

        wait_tick("p2", n);
        check("p2_sel", 32'(select), 32'd2);
        check("p2_q",   32'(Q), 32'd1);
        check("p2_pd",  32'(phase_done), 32'd1);
        wait_tick("p2b", n);
        check("p2b_q",  32'(Q), 32'd0);
        check("p2b_pd", 32'(phase_done), 32'd0);

        wait_tick("wrap", n);
        check("wrap_sel", 32'(select), 32'd0);
        check("wrap_q",   32'(Q), 32'd2);
        check("wrap_pd",  32'(phase_done), 32'd1);
        check("wrap_cd",  32'(cycle_done), 32'd1);

        // pause two cycles after a tick, then resume the partial prescale
        step(2);
        En = 1'b0;
        q0 = Q; s0 = select; bad = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (Q != q0 || select != s0 || tick) bad++;
        end
        check("pause_frozen", 32'(bad), 32'd0);
        En = 1'b1;
        wait_tick("resume", n);
        check("resume_lat", 32'(n), 32'd2);
        check("resume_q",   32'(Q), 32'd1);

        // walk to phase 2 and show t is not resampled mid-phase
        wait_tick("w0", n);
        wait_tick("w1", n);
        wait_tick("w2", n);
        check("w2_sel", 32'(select), 32'd2);
        check("w2_q",   32'(Q), 32'd1);
        t = {7'd2, 7'd0, 7'd9};
        wait_tick("midt", n);
        check("midt_q", 32'(Q), 32'd0);

        // mid-phase reload with new phase 0 duration
        step(1);
        t = {7'd5, 7'd0, 7'd9};
        enSet = 1'b1;
        step(1);
        check("reload_sel",  32'(select), 32'd0);
        check("reload_q",    32'(Q), 32'd5);
        check("reload_pd",   32'(phase_done), 32'd0);
        check("reload_cd",   32'(cycle_done), 32'd0);
        check("reload_tick", 32'(tick), 32'd0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (tick || Q != 7'd5) bad++;
        end
        check("enset_over_en", 32'(bad), 32'd0);
        enSet = 1'b0;
        wait_tick("rl", n);
        check("rl_lat", 32'(n), 32'd4);
        check("rl_q",   32'(Q), 32'd4);

        // reset mid-count
        step(1);
        RST = 1'b1;
        step(1);
        check("mrst_q",   32'(Q), 32'd0);
        check("mrst_sel", 32'(select), 32'd0);
        check("mrst_tick", 32'(tick), 32'd0);
        check("mrst_pd",  32'(phase_done), 32'd0);
        check("mrst_cd",  32'(cycle_done), 32'd0);
`ifdef COUNTDOWN_BCD_EN
        check("mrst_bcd", 32'(Q_bcd), 32'h0);
`endif
        RST = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (tick || Q != '0) bad++;
        end
        check("post_rst_idle", 32'(bad), 32'd0);

        // full-scale duration
        t = {7'd127, 7'd0, 7'd1};
        enSet = 1'b1;
        step(1);
        check("max_q", 32'(Q), 32'd127);
`ifdef COUNTDOWN_BCD_EN
        check("bcd_127", 32'(Q_bcd), 32'h127);
`endif
        enSet = 1'b0;
        wait_tick("max", n);
        check("max_q_dec", 32'(Q), 32'd126);
`ifdef COUNTDOWN_BCD_EN
        check("bcd_126", 32'(Q_bcd), 32'h126);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
